// File: rtl/echo_delay_scheduler_if.sv
// Codec handshake and delay-line RAM port bundle for echo_delay_scheduler.
// master = scheduler side, slave = codec core / RAM side.
interface echo_delay_scheduler_if #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned PRECISION  = 8,
  parameter int unsigned PTR_WIDTH  = 15
);
  logic                  read_ready;
  logic                  write_ready;
  logic [DATA_WIDTH-1:0] readdata_left;
  logic [DATA_WIDTH-1:0] readdata_right;
  logic                  read;
  logic                  write;
  logic [DATA_WIDTH-1:0] writedata_left;
  logic [DATA_WIDTH-1:0] writedata_right;
  logic [PTR_WIDTH:0]    mem_addr;
  logic                  mem_wren;
  logic [PRECISION-1:0]  mem_wdata;
  logic [PRECISION-1:0]  mem_rdata;
  logic                  busy;

  modport master (
    input  read_ready, write_ready, readdata_left, readdata_right, mem_rdata,
    output read, write, writedata_left, writedata_right,
           mem_addr, mem_wren, mem_wdata, busy
  );

  modport slave (
    output read_ready, write_ready, readdata_left, readdata_right, mem_rdata,
    input  read, write, writedata_left, writedata_right,
           mem_addr, mem_wren, mem_wdata, busy
  );
endinterface

// File: rtl/echo_delay_scheduler.sv
// Stereo echo controller: decimates codec samples, sequences a shared single-port
// delay-line RAM (L/R read-before-write per slot) and mixes live/2 + echo.
module echo_delay_scheduler #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned PRECISION  = 8,
  parameter int unsigned SKIP_RATE  = 4,
  parameter int unsigned DEPTH      = 24000,
  parameter int unsigned PTR_WIDTH  = 15
) (
  input  logic                   clk,
  input  logic                   reset_n,
  echo_delay_scheduler_if.master bus
);
  localparam int unsigned          SHIFT    = DATA_WIDTH - PRECISION;
  localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(DEPTH - 1);
  localparam logic [3:0]           LAST_DEC = 4'(SKIP_RATE - 1);

  typedef enum logic [2:0] {CLEAR, IDLE, RD_L, RD_R, WR_L, WR_R, MIX} state_e;

  state_e                state_q, state_d;
  logic [PTR_WIDTH-1:0]  ptr_q, ptr_d;
  logic                  clr_ch_q, clr_ch_d;
  logic [3:0]            dec_cnt_q, dec_cnt_d;
  logic [DATA_WIDTH-1:0] smp_l_q, smp_l_d, smp_r_q, smp_r_d;
  logic [DATA_WIDTH-1:0] echo_l_q, echo_l_d, echo_r_q, echo_r_d;
  logic [DATA_WIDTH-1:0] wd_l_q, wd_l_d, wd_r_q, wd_r_d;
  logic                  out_pending_q, out_pending_d;
  logic [PTR_WIDTH:0]    mem_addr_q, mem_addr_d;
  logic                  mem_wren_q, mem_wren_d;
  logic [PRECISION-1:0]  mem_wdata_q, mem_wdata_d;
  logic signed [DATA_WIDTH-1:0] half_l, half_r;
  logic                  rd_hs, wr_hs;

  assign rd_hs  = (state_q == IDLE) && bus.read_ready && !out_pending_q;
  assign wr_hs  = bus.write_ready && out_pending_q;
  assign half_l = $signed(smp_l_q) >>> 1;
  assign half_r = $signed(smp_r_q) >>> 1;

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    clr_ch_d      = clr_ch_q;
    dec_cnt_d     = dec_cnt_q;
    smp_l_d       = smp_l_q;
    smp_r_d       = smp_r_q;
    echo_l_d      = echo_l_q;
    echo_r_d      = echo_r_q;
    wd_l_d        = wd_l_q;
    wd_r_d        = wd_r_q;
    out_pending_d = out_pending_q;
    if (wr_hs) out_pending_d = 1'b0;

    unique case (state_q)
      CLEAR: begin
        // RAM port is registered: the first CLEAR cycle after reset only loads
        // the L0 write; the walk advances once a write is actually on the bus.
        if (mem_wren_q) begin
          if (clr_ch_q && (ptr_q == LAST_PTR)) begin
            state_d  = IDLE;
            ptr_d    = '0;
            clr_ch_d = 1'b0;
          end else begin
            clr_ch_d = !clr_ch_q;
            if (clr_ch_q) ptr_d = ptr_q + 1'b1;
          end
        end
      end
      IDLE: begin
        if (rd_hs) begin
          smp_l_d = bus.readdata_left;
          smp_r_d = bus.readdata_right;
          if (dec_cnt_q == LAST_DEC) begin
            dec_cnt_d = '0;
            state_d   = RD_L;
          end else begin
            dec_cnt_d = dec_cnt_q + 1'b1;
            state_d   = MIX;
          end
        end
      end
      RD_L: state_d = RD_R;
      RD_R: begin
        echo_l_d = DATA_WIDTH'(bus.mem_rdata) << SHIFT;
        state_d  = WR_L;
      end
      WR_L: begin
        echo_r_d = DATA_WIDTH'(bus.mem_rdata) << SHIFT;
        state_d  = WR_R;
      end
      WR_R: begin
        ptr_d   = (ptr_q == LAST_PTR) ? '0 : ptr_q + 1'b1;
        state_d = MIX;
      end
      MIX: begin
        wd_l_d        = echo_l_q + $unsigned(half_l);
        wd_r_d        = echo_r_q + $unsigned(half_r);
        out_pending_d = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = CLEAR;
    endcase
  end

  // RAM outputs are registered from the state being entered, so they line up
  // with state_q and read data returns in the following state.
  always_comb begin
    mem_addr_d  = '0;
    mem_wren_d  = 1'b0;
    mem_wdata_d = '0;
    unique case (state_d)
      CLEAR: begin
        mem_addr_d = {clr_ch_d, ptr_d};
        mem_wren_d = 1'b1;
      end
      RD_L: mem_addr_d = {1'b0, ptr_d};
      RD_R: mem_addr_d = {1'b1, ptr_d};
      WR_L: begin
        mem_addr_d  = {1'b0, ptr_d};
        mem_wren_d  = 1'b1;
        mem_wdata_d = smp_l_d[DATA_WIDTH-1 -: PRECISION];
      end
      WR_R: begin
        mem_addr_d  = {1'b1, ptr_d};
        mem_wren_d  = 1'b1;
        mem_wdata_d = smp_r_d[DATA_WIDTH-1 -: PRECISION];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= CLEAR;
      ptr_q         <= '0;
      clr_ch_q      <= 1'b0;
      dec_cnt_q     <= '0;
      smp_l_q       <= '0;
      smp_r_q       <= '0;
      echo_l_q      <= '0;
      echo_r_q      <= '0;
      wd_l_q        <= '0;
      wd_r_q        <= '0;
      out_pending_q <= 1'b0;
      mem_addr_q    <= '0;
      mem_wren_q    <= 1'b0;
      mem_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      clr_ch_q      <= clr_ch_d;
      dec_cnt_q     <= dec_cnt_d;
      smp_l_q       <= smp_l_d;
      smp_r_q       <= smp_r_d;
      echo_l_q      <= echo_l_d;
      echo_r_q      <= echo_r_d;
      wd_l_q        <= wd_l_d;
      wd_r_q        <= wd_r_d;
      out_pending_q <= out_pending_d;
      mem_addr_q    <= mem_addr_d;
      mem_wren_q    <= mem_wren_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  assign bus.read            = rd_hs;
  assign bus.write           = wr_hs;
  assign bus.writedata_left  = wd_l_q;
  assign bus.writedata_right = wd_r_q;
  assign bus.mem_addr        = mem_addr_q;
  assign bus.mem_wren        = mem_wren_q;
  assign bus.mem_wdata       = mem_wdata_q;
  assign bus.busy            = (state_q != IDLE);
endmodule

// File: tb/tb_echo_delay_scheduler.sv
// Bench for echo_delay_scheduler: RAM model plus an array-based echo reference,
// driven by directed and random sample sequences.
module tb_echo_delay_scheduler;
  localparam int unsigned DW   = 24;
  localparam int unsigned PREC = 8;
  localparam int unsigned SKIP = 2;
  localparam int unsigned DEP  = 4;
  localparam int unsigned PW   = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  echo_delay_scheduler_if #(.DATA_WIDTH(DW), .PRECISION(PREC), .PTR_WIDTH(PW)) bus ();

  echo_delay_scheduler #(
    .DATA_WIDTH(DW), .PRECISION(PREC), .SKIP_RATE(SKIP), .DEPTH(DEP), .PTR_WIDTH(PW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  logic [PREC-1:0] ram [2**(PW+1)];
  always @(posedge clk) begin
    if (bus.mem_wren) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: two circular delay lines of sample MSBs, one slot per SKIP samples.
  int unsigned m_line_l [DEP];
  int unsigned m_line_r [DEP];
  int unsigned m_wp, m_hs;
  int          m_echo_l, m_echo_r;

  function automatic void model_reset();
    for (int i = 0; i < int'(DEP); i++) begin
      m_line_l[i] = 0;
      m_line_r[i] = 0;
    end
    m_wp = 0; m_hs = 0; m_echo_l = 0; m_echo_r = 0;
  endfunction

  function automatic void model_step(input logic [DW-1:0] l, input logic [DW-1:0] r,
                                     output logic [DW-1:0] el, output logic [DW-1:0] er,
                                     output bit dec, output int unsigned ptr);
    int sl, sr;
    dec = ((m_hs % SKIP) == SKIP - 1);
    m_hs++;
    ptr = m_wp;
    if (dec) begin
      m_echo_l = int'(m_line_l[m_wp]) * (2 ** (DW - PREC));
      m_echo_r = int'(m_line_r[m_wp]) * (2 ** (DW - PREC));
      m_line_l[m_wp] = int'(l) / (2 ** (DW - PREC));
      m_line_r[m_wp] = int'(r) / (2 ** (DW - PREC));
      m_wp = (m_wp + 1) % DEP;
    end
    sl = int'($signed(l));
    sr = int'($signed(r));
    el = DW'((m_echo_l + (sl >>> 1)) & ((1 << DW) - 1));
    er = DW'((m_echo_r + (sr >>> 1)) & ((1 << DW) - 1));
  endfunction

  logic [DW-1:0] last_wl, last_wr;

  task automatic reset_checks(input string tag);
    chk({tag, "_read"},  32'(bus.read), 0);
    chk({tag, "_write"}, 32'(bus.write), 0);
    chk({tag, "_wren"},  32'(bus.mem_wren), 0);
    chk({tag, "_addr"},  32'(bus.mem_addr), 0);
    chk({tag, "_wdata"}, 32'(bus.mem_wdata), 0);
    chk({tag, "_wd_l"},  32'(bus.writedata_left), 0);
    chk({tag, "_wd_r"},  32'(bus.writedata_right), 0);
    chk({tag, "_busy"},  32'(bus.busy), 1);
  endtask

  // Entered right after reset release with read_ready high.
  task automatic clear_check(input string tag);
    int unsigned nw, k;
    nw = 0; k = 0;
    while (k < 4 * DEP + 8) begin
      @(negedge clk); k++;
      if (!bus.busy) break;
      chk({tag, "_read_low"}, 32'(bus.read), 0);
      if (bus.mem_wren) begin
        chk({tag, "_addr"}, 32'(bus.mem_addr), (nw % 2) * (2 ** PW) + nw / 2);
        chk({tag, "_data"}, 32'(bus.mem_wdata), 0);
        nw++;
      end
    end
    bus.read_ready = 1'b0;
    chk({tag, "_busy_drop"}, 32'(bus.busy), 0);
    chk({tag, "_writes"}, nw, 2 * DEP);
    chk({tag, "_idle_wren"}, 32'(bus.mem_wren), 0);
  endtask

  task automatic do_sample(input logic [DW-1:0] l, input logic [DW-1:0] r,
                           input int unsigned wdelay, input bit rr_hold);
    logic [DW-1:0] el, er;
    logic [PW:0]   first_addr;
    bit            dec;
    int unsigned   ptr, k, nwr, lat, exp_k;
    model_step(l, r, el, er, dec, ptr);
    lat   = dec ? 6 : 2;
    exp_k = (wdelay > lat) ? wdelay : lat;
    first_addr = '0;
    @(negedge clk);
    bus.readdata_left = l; bus.readdata_right = r; bus.read_ready = 1'b1;
    #1;
    k = 0;
    while (!bus.read && k < 50) begin @(negedge clk); #1; k++; end
    chk("hs_timeout", 32'(k < 50), 1);
    @(posedge clk); #1;
    if (!rr_hold) bus.read_ready = 1'b0;
    bus.write_ready = (wdelay == 0);
    k = 0; nwr = 0;
    while (k < 60) begin
      @(negedge clk); k++;
      if (k == wdelay) bus.write_ready = 1'b1;
      #1;
      if (bus.mem_wren) begin
        if (nwr == 0) first_addr = bus.mem_addr;
        nwr++;
      end
      if (bus.write) break;
      if (rr_hold) chk("bp_read_low", 32'(bus.read), 0);
      if (rr_hold && k > lat) chk("bp_hold_l", 32'(bus.writedata_left), 32'(el));
    end
    chk("write_latency", k, exp_k);
    chk("wd_left", 32'(bus.writedata_left), 32'(el));
    chk("wd_right", 32'(bus.writedata_right), 32'(er));
    if (rr_hold) chk("both_ready_read_low", 32'(bus.read), 0);
    chk("ram_writes", nwr, dec ? 2 : 0);
    if (dec) chk("ram_wr_addr", 32'(first_addr), ptr);
    last_wl = bus.writedata_left;
    last_wr = bus.writedata_right;
    @(posedge clk); #1;
    chk("write_single", 32'(bus.write), 0);
    if (rr_hold) chk("read_after_write", 32'(bus.read), 1);
    bus.read_ready = 1'b0;
    bus.write_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned k;
    reset_n = 1'b0;
    bus.read_ready = 1'b1;
    bus.write_ready = 1'b0;
    bus.readdata_left = '0;
    bus.readdata_right = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_checks("rst");
    reset_n = 1'b1;
    clear_check("clr");
    model_reset();

    for (int i = 0; i < int'(3 * DEP * SKIP); i++) begin
      do_sample(24'h400000, 24'h400000, 0, 1'b0);
      if (i == 0) chk("const_first", 32'(last_wl), 32'h200000);
    end
    chk("const_last_l", 32'(last_wl), 32'h600000);
    chk("const_last_r", 32'(last_wr), 32'h600000);

    for (int i = 0; i < 40; i++)
      do_sample(DW'($urandom), DW'($urandom), $urandom_range(0, 8), 1'($urandom_range(0, 1)));

    do_sample(24'h123456, 24'hEDCBA9, 20, 1'b1);

    for (int i = 0; i < int'((DEP + 2) * SKIP); i++)
      do_sample(24'h7FFFFE, 24'h7FFFFE, 0, 1'b0);
    chk("ovf_left", 32'(last_wl), 32'hBEFFFF);
    chk("ovf_right", 32'(last_wr), 32'hBEFFFF);

    while ((m_hs % SKIP) != SKIP - 1)
      do_sample(DW'($urandom), DW'($urandom), 0, 1'b0);
    @(negedge clk);
    bus.readdata_left = 24'h55AA55; bus.readdata_right = 24'hAA55AA; bus.read_ready = 1'b1;
    #1;
    chk("wrl_hs", 32'(bus.read), 1);
    @(posedge clk); #1;
    bus.read_ready = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end
    while (!(bus.mem_wren && !bus.mem_addr[PW]) && k < 20);
    chk("wrl_reached", 32'(k < 20), 1);
    #1 reset_n = 1'b0;
    bus.write_ready = 1'b1;
    #1;
    reset_checks("mid_rst");
    @(negedge clk);
    bus.read_ready = 1'b1;
    reset_n = 1'b1;
    clear_check("reclr");
    bus.write_ready = 1'b0;
    model_reset();
    do_sample(24'h400000, 24'hC00000, 0, 1'b0);
    chk("post_reset_l", 32'(last_wl), 32'h200000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
